// File: rtl/mem_access_stage_if.sv
// Execute -> memory-access -> write-back handshake plus the data-memory port.
// The stage takes the slave modport; the surrounding pipeline/memory model
// takes the master modport.
// Optional feature macro: MEM_MISALIGN_CHECK_EN adds misalign_fault.
//
// Handshake: a transfer happens on a rising clk edge where the sender's
// ReadyToSend and the receiver's ReadyToRcv are both 1. The sender holds its
// data stable while ReadyToSend=1 and no transfer has happened yet.
`timescale 1ns/1ps
interface mem_access_stage_if #(
    parameter int XLEN     = 32,
    parameter int REGIDX_W = 5
);
    // upstream (execute side)
    logic                prevPipReadyToSend;
    logic                curPipReadyToRcv;
    logic                in_isLsUopUse;
    logic                in_isMemLoad;
    logic [1:0]          in_ldsize;
    logic                in_ldSignExt;
    logic [XLEN-1:0]     in_addr;
    logic [XLEN-1:0]     in_storeVal;
    logic                in_rd_valid;
    logic [REGIDX_W-1:0] in_rd_idx;
    logic [XLEN-1:0]     in_rd_val;
    // downstream (write-back side)
    logic                curPipReadyToSend;
    logic                nextPipReadyToRcv;
    logic                out_rd_valid;
    logic [REGIDX_W-1:0] out_rd_idx;
    logic [XLEN-1:0]     out_rd_val;
    // data memory
    logic                mem_req;
    logic                mem_we;
    logic [XLEN-1:0]     mem_addr;
    logic [XLEN-1:0]     mem_wdata;
    logic [3:0]          mem_wmask;
    logic [XLEN-1:0]     mem_rdata;
    logic                mem_fin;
`ifdef MEM_MISALIGN_CHECK_EN
    logic                misalign_fault;
`endif

    modport slave (
        input  prevPipReadyToSend, in_isLsUopUse, in_isMemLoad, in_ldsize,
               in_ldSignExt, in_addr, in_storeVal, in_rd_valid, in_rd_idx,
               in_rd_val, nextPipReadyToRcv, mem_rdata, mem_fin,
        output curPipReadyToRcv, curPipReadyToSend, out_rd_valid, out_rd_idx,
               out_rd_val, mem_req, mem_we, mem_addr, mem_wdata, mem_wmask
`ifdef MEM_MISALIGN_CHECK_EN
               , misalign_fault
`endif
    );

    modport master (
        output prevPipReadyToSend, in_isLsUopUse, in_isMemLoad, in_ldsize,
               in_ldSignExt, in_addr, in_storeVal, in_rd_valid, in_rd_idx,
               in_rd_val, nextPipReadyToRcv, mem_rdata, mem_fin,
        input  curPipReadyToRcv, curPipReadyToSend, out_rd_valid, out_rd_idx,
               out_rd_val, mem_req, mem_we, mem_addr, mem_wdata, mem_wmask
`ifdef MEM_MISALIGN_CHECK_EN
               , misalign_fault
`endif
    );
endinterface

// File: rtl/mem_access_stage.sv
// Load/store stage of the multicycle RV32I pipeline. Latches one uop from
// execute, runs at most one memory transaction for load/store uops (byte-lane
// steering on stores, shift + sign/zero extension on loads) and hands the
// destination register to write-back. Non-LS uops pass through in one cycle.
// Optional feature macro: MEM_MISALIGN_CHECK_EN (misaligned LS uops are
// dropped with a one-cycle misalign_fault pulse instead of touching memory).
// dbg_state exposes the FSM state: 0 idle, 1 waitBef, 2 sending, 3 waitSend.
`timescale 1ns/1ps
module mem_access_stage #(
    parameter int XLEN     = 32,
    parameter int REGIDX_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    mem_access_stage_if.slave     bus,
    output logic [1:0]            dbg_state
);

    typedef enum logic [1:0] {
        idle_state      = 2'd0,
        wait_bef_state  = 2'd1,
        sending_state   = 2'd2,
        wait_send_state = 2'd3
    } state_t;

    state_t              state;
    logic                rdy_rcv_r;
    logic                rdy_send_r;
    logic                is_load_r;
    logic [1:0]          ldsize_r;
    logic                signext_r;
    logic [1:0]          off_r;
    logic                rd_valid_r;
    logic [REGIDX_W-1:0] rd_idx_r;
    logic [XLEN-1:0]     rd_val_r;
    logic                mem_req_r;
    logic                mem_we_r;
    logic [XLEN-1:0]     mem_addr_r;
    logic [XLEN-1:0]     mem_wdata_r;
    logic [3:0]          mem_wmask_r;
`ifdef MEM_MISALIGN_CHECK_EN
    logic                fault_r;
`endif

    logic                in_mis;
    logic [XLEN-1:0]     st_wdata;
    logic [3:0]          st_wmask;
    logic [1:0]          ld_off;
    logic [XLEN-1:0]     ld_sh;
    logic [XLEN-1:0]     ld_ext;
    logic                fin_hit;
    logic                done;

    // Misalignment of the incoming uop; ldsize=11 behaves as a word access.
`ifdef MEM_MISALIGN_CHECK_EN
    assign in_mis = bus.in_isLsUopUse &
                    (((bus.in_ldsize == 2'b01) & bus.in_addr[0]) |
                     (bus.in_ldsize[1] & (bus.in_addr[1:0] != 2'b00)));
`else
    assign in_mis = 1'b0;
`endif

    // Store lane replication and byte enables from the incoming uop.
    always_comb begin
        st_wdata = bus.in_storeVal;
        st_wmask = 4'b1111;
        case (bus.in_ldsize)
            2'b00: begin
                st_wdata = {(XLEN/8){bus.in_storeVal[7:0]}};
                st_wmask = 4'b0001 << bus.in_addr[1:0];
            end
            2'b01: begin
                st_wdata = {(XLEN/16){bus.in_storeVal[15:0]}};
                st_wmask = 4'b0011 << {bus.in_addr[1], 1'b0};
            end
            default: begin
                st_wdata = bus.in_storeVal;
                st_wmask = 4'b1111;
            end
        endcase
    end

    // Load data: shift the addressed lane down, then extend to XLEN.
    always_comb begin
        ld_off = 2'b00;
        case (ldsize_r)
            2'b00:   ld_off = off_r;
            2'b01:   ld_off = {off_r[1], 1'b0};
            default: ld_off = 2'b00;
        endcase
        ld_sh  = bus.mem_rdata >> {ld_off, 3'b000};
        ld_ext = ld_sh;
        case (ldsize_r)
            2'b00:   ld_ext = {{(XLEN-8){signext_r & ld_sh[7]}}, ld_sh[7:0]};
            2'b01:   ld_ext = {{(XLEN-16){signext_r & ld_sh[15]}}, ld_sh[15:0]};
            default: ld_ext = ld_sh;
        endcase
    end

    // mem_req is only high in sendingState for an LS uop, so a fin seen while
    // it is low is by construction outside an outstanding transaction.
    assign fin_hit = mem_req_r & bus.mem_fin;
    // rdy_send_r is preset on entry to sendingState for uops that need no memory.
    assign done    = rdy_send_r | fin_hit;

    // Pipeline control FSM with registered handshake and memory-side outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= idle_state;
            rdy_rcv_r   <= 1'b0;
            rdy_send_r  <= 1'b0;
            is_load_r   <= 1'b0;
            ldsize_r    <= 2'b00;
            signext_r   <= 1'b0;
            off_r       <= 2'b00;
            rd_valid_r  <= 1'b0;
            rd_idx_r    <= '0;
            rd_val_r    <= '0;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= '0;
            mem_wdata_r <= '0;
            mem_wmask_r <= 4'b0000;
`ifdef MEM_MISALIGN_CHECK_EN
            fault_r     <= 1'b0;
`endif
        end else begin
            case (state)
                idle_state: begin
                    state     <= wait_bef_state;
                    rdy_rcv_r <= 1'b1;
                end
                wait_bef_state: begin
                    if (bus.prevPipReadyToSend) begin
                        state     <= sending_state;
                        rdy_rcv_r <= 1'b0;
                        is_load_r <= bus.in_isMemLoad;
                        ldsize_r  <= bus.in_ldsize;
                        signext_r <= bus.in_ldSignExt;
                        off_r     <= bus.in_addr[1:0];
                        rd_idx_r  <= bus.in_rd_idx;
                        if (!bus.in_isLsUopUse) begin
                            rd_valid_r <= bus.in_rd_valid;
                            rd_val_r   <= bus.in_rd_val;
                            rdy_send_r <= 1'b1;
                            mem_we_r   <= 1'b0;
                        end else if (in_mis) begin
                            rd_valid_r <= 1'b0;
                            rd_val_r   <= '0;
                            rdy_send_r <= 1'b1;
                            mem_we_r   <= 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
                            fault_r    <= 1'b1;
`endif
                        end else begin
                            rd_valid_r  <= bus.in_isMemLoad & bus.in_rd_valid;
                            rd_val_r    <= '0;
                            rdy_send_r  <= 1'b0;
                            mem_req_r   <= 1'b1;
                            mem_we_r    <= ~bus.in_isMemLoad;
                            mem_addr_r  <= {bus.in_addr[XLEN-1:2], 2'b00};
                            mem_wdata_r <= st_wdata;
                            mem_wmask_r <= st_wmask;
                        end
                    end
                end
                sending_state: begin
                    if (done) begin
                        mem_req_r <= 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
                        fault_r   <= 1'b0;
`endif
                        // Keep the load result for a stalled write-back.
                        if (fin_hit && is_load_r) begin
                            rd_val_r <= ld_ext;
                        end
                        if (bus.nextPipReadyToRcv) begin
                            state      <= wait_bef_state;
                            rdy_send_r <= 1'b0;
                            rdy_rcv_r  <= 1'b1;
                        end else begin
                            state      <= wait_send_state;
                            rdy_send_r <= 1'b1;
                        end
                    end
                end
                wait_send_state: begin
                    if (bus.nextPipReadyToRcv) begin
                        state      <= wait_bef_state;
                        rdy_send_r <= 1'b0;
                        rdy_rcv_r  <= 1'b1;
                    end
                end
                default: state <= idle_state;
            endcase
        end
    end

    assign bus.curPipReadyToRcv  = rdy_rcv_r;
    assign bus.curPipReadyToSend = rdy_send_r | fin_hit;
    assign bus.out_rd_valid      = rd_valid_r;
    assign bus.out_rd_idx        = rd_idx_r;
    assign bus.out_rd_val        = (fin_hit && is_load_r) ? ld_ext : rd_val_r;
    assign bus.mem_req           = mem_req_r;
    assign bus.mem_we            = mem_we_r;
    assign bus.mem_addr          = mem_addr_r;
    assign bus.mem_wdata         = mem_wdata_r;
    assign bus.mem_wmask         = mem_wmask_r;
`ifdef MEM_MISALIGN_CHECK_EN
    assign bus.misalign_fault    = fault_r;
`endif
    assign dbg_state             = state;

endmodule
